segre_lsu: RTL and testbench

//  Load/store unit; the responder for the memop requests produced by instruction decode.

---
 rtl/segre_pkg.sv | 19 +
 rtl/segre_lsu_align.sv | 51 +++++
 rtl/segre_lsu.sv | 181 ++++++++++++++++++
 tb/tb_segre_lsu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/segre_pkg.sv
// Shared types for the segre core slice: memop encodings and LSU state.
package segre_pkg;

   localparam int WORD_SIZE = 32;
   localparam int REG_SIZE  = 5;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } memop_data_type_e;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'b00,
      LSU_REQ  = 2'b01,
      LSU_WAIT = 2'b10
   } lsu_state_e;

endpackage

// File: rtl/segre_lsu_align.sv
// Lane logic for the LSU: store byte enables / data replication, alignment check,
// and load lane extraction with zero/sign extension.
module segre_lsu_align
   import segre_pkg::*;
(
   input  memop_data_type_e     st_type_i,
   input  logic [1:0]           st_alo_i,
   input  logic [WORD_SIZE-1:0] st_data_i,
   output logic [3:0]           st_be_o,
   output logic [WORD_SIZE-1:0] st_wdata_o,
   output logic                 st_misaligned_o,
   input  memop_data_type_e     ld_type_i,
   input  logic [1:0]           ld_alo_i,
   input  logic                 ld_sign_ext_i,
   input  logic [WORD_SIZE-1:0] ld_rdata_i,
   output logic [WORD_SIZE-1:0] ld_data_o
);

   logic [WORD_SIZE-1:0] shifted;

   assign shifted = ld_rdata_i >> {ld_alo_i, 3'b000};

   always_comb begin
      st_be_o         = 4'b1111;
      st_wdata_o      = st_data_i;
      st_misaligned_o = 1'b0;
      case (st_type_i)
         BYTE: begin
            st_be_o    = 4'b0001 << st_alo_i;
            st_wdata_o = {4{st_data_i[7:0]}};
         end
         HALF: begin
            st_be_o         = 4'b0011 << st_alo_i;
            st_wdata_o      = {2{st_data_i[15:0]}};
            st_misaligned_o = st_alo_i[0];
         end
         WORD: st_misaligned_o = |st_alo_i;
         default: ;
      endcase
   end

   always_comb begin
      ld_data_o = ld_rdata_i;
      case (ld_type_i)
         BYTE: ld_data_o = {{24{ld_sign_ext_i & shifted[7]}}, shifted[7:0]};
         HALF: ld_data_o = {{16{ld_sign_ext_i & shifted[15]}}, shifted[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/segre_lsu.sv
// Load/store unit: accepts one memop at a time, runs it over a req/gnt/rvalid bus,
// and reports load results, store completion, misalignment or timeout as 1-cycle pulses.
module segre_lsu
   import segre_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   input  logic                  memop_rd_i,
   input  logic                  memop_wr_i,
   input  memop_data_type_e      memop_type_i,
   input  logic                  memop_sign_ext_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [WORD_SIZE-1:0]  wdata_i,
   input  logic [REG_SIZE-1:0]   rf_waddr_i,
   output logic                  busy_o,
   output logic                  load_valid_o,
   output logic [WORD_SIZE-1:0]  load_data_o,
   output logic [REG_SIZE-1:0]   load_waddr_o,
   output logic                  store_done_o,
   output logic                  misaligned_o,
   output logic                  bus_err_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [WORD_SIZE-1:0]  mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [WORD_SIZE-1:0]  mem_rdata_i
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   lsu_state_e            state_q;
   logic                  busy_q, mem_req_q, mem_we_q;
   logic [3:0]            mem_be_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [WORD_SIZE-1:0]  mem_wdata_q, load_data_q;
   memop_data_type_e      type_q;
   logic                  sign_q;
   logic [1:0]            alo_q;
   logic [REG_SIZE-1:0]   waddr_q, load_waddr_q;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  load_valid_q, store_done_q, misaligned_q, bus_err_q;

   logic                  accept, timeout, st_misaligned;
   logic [3:0]            st_be;
   logic [WORD_SIZE-1:0]  st_wdata, ld_data;

   segre_lsu_align u_align (
      .st_type_i       (memop_type_i),
      .st_alo_i        (addr_i[1:0]),
      .st_data_i       (wdata_i),
      .st_be_o         (st_be),
      .st_wdata_o      (st_wdata),
      .st_misaligned_o (st_misaligned),
      .ld_type_i       (type_q),
      .ld_alo_i        (alo_q),
      .ld_sign_ext_i   (sign_q),
      .ld_rdata_i      (mem_rdata_i),
      .ld_data_o       (ld_data)
   );

   assign accept  = req_valid_i & (memop_rd_i ^ memop_wr_i);
   assign cnt_d   = cnt_q + CW'(1);
   // The current REQ/WAIT cycle is the TIMEOUT_CYCLES-th one since accept.
   assign timeout = (cnt_q == TO_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= LSU_IDLE;
         busy_q       <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_be_q     <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         type_q       <= BYTE;
         sign_q       <= 1'b0;
         alo_q        <= '0;
         waddr_q      <= '0;
         cnt_q        <= '0;
         load_valid_q <= 1'b0;
         load_data_q  <= '0;
         load_waddr_q <= '0;
         store_done_q <= 1'b0;
         misaligned_q <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         load_valid_q <= 1'b0;
         store_done_q <= 1'b0;
         misaligned_q <= 1'b0;
         bus_err_q    <= 1'b0;
         case (state_q)
            LSU_IDLE: begin
               if (accept && st_misaligned) begin
                  misaligned_q <= 1'b1;
               end else if (accept) begin
                  state_q     <= LSU_REQ;
                  busy_q      <= 1'b1;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= memop_wr_i;
                  mem_be_q    <= st_be;
                  mem_addr_q  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                  mem_wdata_q <= st_wdata;
                  type_q      <= memop_type_i;
                  sign_q      <= memop_sign_ext_i;
                  alo_q       <= addr_i[1:0];
                  waddr_q     <= rf_waddr_i;
                  cnt_q       <= '0;
               end
            end
            LSU_REQ: begin
               if (mem_gnt_i && mem_we_q) begin
                  mem_req_q    <= 1'b0;
                  store_done_q <= 1'b1;
                  state_q      <= LSU_IDLE;
                  busy_q       <= 1'b0;
               end else if (mem_gnt_i && mem_rvalid_i) begin
                  mem_req_q    <= 1'b0;
                  load_valid_q <= 1'b1;
                  load_data_q  <= ld_data;
                  load_waddr_q <= waddr_q;
                  state_q      <= LSU_IDLE;
                  busy_q       <= 1'b0;
               end else if (timeout) begin
                  mem_req_q <= 1'b0;
                  bus_err_q <= 1'b1;
                  state_q   <= LSU_IDLE;
                  busy_q    <= 1'b0;
               end else begin
                  cnt_q <= cnt_d;
                  if (mem_gnt_i) begin
                     mem_req_q <= 1'b0;
                     state_q   <= LSU_WAIT;
                  end
               end
            end
            LSU_WAIT: begin
               if (mem_rvalid_i) begin
                  load_valid_q <= 1'b1;
                  load_data_q  <= ld_data;
                  load_waddr_q <= waddr_q;
                  state_q      <= LSU_IDLE;
                  busy_q       <= 1'b0;
               end else if (timeout) begin
                  bus_err_q <= 1'b1;
                  state_q   <= LSU_IDLE;
                  busy_q    <= 1'b0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q   <= LSU_IDLE;
               busy_q    <= 1'b0;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o       = busy_q;
   assign load_valid_o = load_valid_q;
   assign load_data_o  = load_data_q;
   assign load_waddr_o = load_waddr_q;
   assign store_done_o = store_done_q;
   assign misaligned_o = misaligned_q;
   assign bus_err_o    = bus_err_q;
   assign mem_req_o    = mem_req_q;
   assign mem_we_o     = mem_we_q;
   assign mem_be_o     = mem_be_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_segre_lsu.sv
// Directed bench for segre_lsu: bus responder driver, response scoreboard, final report.
module tb_segre_lsu;
   import segre_pkg::*;

   localparam int W = 39;
   localparam logic [1:0] K_LOAD = 2'd0, K_STORE = 2'd1, K_MIS = 2'd2, K_BUSERR = 2'd3;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic req_valid_i = 1'b0, memop_rd_i = 1'b0, memop_wr_i = 1'b0, memop_sign_ext_i = 1'b0;
   memop_data_type_e memop_type_i = BYTE;
   logic [31:0] addr_i = '0, wdata_i = '0, mem_rdata_i = '0;
   logic [4:0]  rf_waddr_i = '0;
   logic mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
   logic busy_o, load_valid_o, store_done_o, misaligned_o, bus_err_o, mem_req_o, mem_we_o;
   logic [31:0] load_data_o, mem_addr_o, mem_wdata_o;
   logic [4:0]  load_waddr_o;
   logic [3:0]  mem_be_o;

   logic [W-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;
   int busy_total = 0;

   segre_lsu dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .memop_rd_i(memop_rd_i),
      .memop_wr_i(memop_wr_i), .memop_type_i(memop_type_i), .memop_sign_ext_i(memop_sign_ext_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .rf_waddr_i(rf_waddr_i), .busy_o(busy_o),
      .load_valid_o(load_valid_o), .load_data_o(load_data_o), .load_waddr_o(load_waddr_o),
      .store_done_o(store_done_o), .misaligned_o(misaligned_o), .bus_err_o(bus_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i)
   );

   // Clock / watchdog
   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of run, required finish before 2ms");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every response pulse pops one expectation.
   always @(negedge clk_i) begin : mon_blk
      logic [W-1:0] act;
      logic [2:0]   npulse;
      if (busy_o) busy_total++;
      if (!rst_i) begin
         npulse = 3'(load_valid_o) + 3'(store_done_o) + 3'(misaligned_o) + 3'(bus_err_o);
         act = '0;
         if (load_valid_o)      act = {K_LOAD, load_data_o, load_waddr_o};
         else if (store_done_o) act = {K_STORE, 37'h0};
         else if (misaligned_o) act = {K_MIS, 37'h0};
         else if (bus_err_o)    act = {K_BUSERR, 37'h0};
         if (npulse > 3'd1) check("pulse_overlap", 64'(npulse), 64'd1);
         if (npulse != 3'd0) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_pulse: got 0x%0h required no response", act);
            end else begin
               check("response", 64'(act), 64'(exp_q.pop_front()));
            end
         end
      end
   end

   // Driver tasks
   task automatic drive_req(input logic rd, input logic wr, input memop_data_type_e t,
                            input logic sx, input logic [31:0] a, input logic [31:0] d,
                            input logic [4:0] wa);
      req_valid_i = 1'b1; memop_rd_i = rd; memop_wr_i = wr; memop_type_i = t;
      memop_sign_ext_i = sx; addr_i = a; wdata_i = d; rf_waddr_i = wa;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && busy_o; i++) @(negedge clk_i);
      check("idle_reached", 64'(busy_o), 64'd0);
   endtask

   task automatic run_op(input logic rd, input logic wr, input memop_data_type_e t, input logic sx,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] wa,
                         input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                         input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eld);
      logic [31:0] ea;
      int start;
      ea = {a[31:2], 2'b00};
      @(negedge clk_i);
      drive_req(rd, wr, t, sx, a, d, wa);
      start = busy_total;
      if (wr) exp_q.push_back({K_STORE, 37'h0});
      else    exp_q.push_back({K_LOAD, eld, wa});
      @(negedge clk_i);
      req_valid_i = 1'b0;
      for (int i = 0; i <= gnt_dly; i++) begin
         if (i > 0) @(negedge clk_i);
         check("req_bus", 64'({mem_req_o, mem_we_o, mem_be_o, mem_addr_o}), 64'({1'b1, wr, ebe, ea}));
         if (wr) check("req_wdata", 64'(mem_wdata_o), 64'(ewd));
         if (i == gnt_dly) begin
            mem_gnt_i = 1'b1;
            if (rd && rv_dly == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i = rdata;
            end
         end
      end
      @(negedge clk_i);
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i = $urandom;
      check("req_drop", 64'(mem_req_o), 64'd0);
      if (rd && rv_dly > 0) begin
         repeat (rv_dly - 1) @(negedge clk_i);
         mem_rvalid_i = 1'b1;
         mem_rdata_i = rdata;
         @(negedge clk_i);
         mem_rvalid_i = 1'b0;
         mem_rdata_i = $urandom;
      end
      wait_idle();
      check("busy_cycles", 64'(busy_total - start), 64'(gnt_dly + 1 + (rd ? rv_dly : 0)));
   endtask

   task automatic run_mis(input memop_data_type_e t, input logic [31:0] a);
      @(negedge clk_i);
      drive_req(1'b1, 1'b0, t, 1'b0, a, 32'h0, 5'd3);
      exp_q.push_back({K_MIS, 37'h0});
      @(negedge clk_i);
      req_valid_i = 1'b0;
      check("mis_quiet0", 64'({busy_o, mem_req_o}), 64'd0);
      @(negedge clk_i);
      check("mis_quiet1", 64'({busy_o, mem_req_o}), 64'd0);
   endtask

   initial begin
      int start;
      // Reset
      repeat (2) @(negedge clk_i);
      check("rst_ctrl", 64'({busy_o, load_valid_o, store_done_o, misaligned_o, bus_err_o,
                             mem_req_o, mem_we_o, mem_be_o}), 64'd0);
      check("rst_data", 64'({mem_addr_o, mem_wdata_o}), 64'd0);
      rst_i = 1'b0;

      // Stores and loads: rd, wr, type, sx, addr, wdata, waddr, gnt_dly, rv_dly, rdata, be, wdata, load
      run_op(0, 1, WORD, 0, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 32'h0, 4'b1111, 32'hDEADBEEF, 32'h0);
      run_op(1, 0, BYTE, 1, 32'h103, 32'h0, 5'd7, 0, 1, 32'h80000000, 4'b1000, 32'h0, 32'hFFFFFF80);
      run_op(1, 0, BYTE, 0, 32'h103, 32'h0, 5'd9, 0, 1, 32'h80000000, 4'b1000, 32'h0, 32'h00000080);
      run_op(1, 0, HALF, 1, 32'h102, 32'h0, 5'd17, 0, 1, 32'hBEEF0000, 4'b1100, 32'h0, 32'hFFFFBEEF);
      run_op(0, 1, HALF, 0, 32'h102, 32'h00001234, 5'd0, 0, 0, 32'h0, 4'b1100, 32'h12341234, 32'h0);
      check("load_data_hold", 64'({load_data_o, load_waddr_o}), 64'({32'hFFFFBEEF, 5'd17}));
      run_op(0, 1, BYTE, 0, 32'h301, 32'h000000AB, 5'd0, 1, 0, 32'h0, 4'b0010, 32'hABABABAB, 32'h0);
      run_op(1, 0, BYTE, 1, 32'h101, 32'h0, 5'd2, 0, 1, 32'h00007F00, 4'b0010, 32'h0, 32'h0000007F);

      // Misalignment and ignored rd&wr request
      run_mis(WORD, 32'h101);
      run_mis(HALF, 32'h0FF);
      @(negedge clk_i);
      drive_req(1'b1, 1'b1, WORD, 1'b0, 32'h200, 32'h0, 5'd1);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      check("rdwr_ignored", 64'({busy_o, mem_req_o}), 64'd0);

      // Late grant / late rvalid, then grant and rvalid together
      run_op(1, 0, WORD, 0, 32'h200, 32'h0, 5'd12, 3, 2, 32'h12345678, 4'b1111, 32'h0, 32'h12345678);
      run_op(1, 0, HALF, 0, 32'h202, 32'h0, 5'd30, 0, 0, 32'hA5A57F01, 4'b1100, 32'h0, 32'h0000A5A5);

      // Timeout with no grant
      @(negedge clk_i);
      drive_req(1'b1, 1'b0, WORD, 1'b0, 32'h400, 32'h0, 5'd5);
      exp_q.push_back({K_BUSERR, 37'h0});
      start = busy_total;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      for (int i = 0; i < 400 && busy_o; i++) @(negedge clk_i);
      check("timeout_busy", 64'(busy_total - start), 64'd255);
      check("timeout_req", 64'({busy_o, mem_req_o}), 64'd0);

      // Reset while waiting for rvalid; the later rvalid must be ignored
      @(negedge clk_i);
      drive_req(1'b1, 1'b0, WORD, 1'b0, 32'h500, 32'h0, 5'd4);
      exp_q.push_back({K_LOAD, 32'h0, 5'd4});
      @(negedge clk_i);
      req_valid_i = 1'b0;
      mem_gnt_i = 1'b1;
      @(negedge clk_i);
      mem_gnt_i = 1'b0;
      check("wait_busy", 64'({busy_o, mem_req_o}), 64'({1'b1, 1'b0}));
      #2 rst_i = 1'b1;
      #1;
      void'(exp_q.pop_back());
      check("midrst_ctrl", 64'({busy_o, load_valid_o, mem_req_o, mem_we_o, mem_be_o}), 64'd0);
      check("midrst_data", 64'({load_data_o, load_waddr_o}), 64'd0);
      check("midrst_bus", 64'({mem_addr_o, mem_wdata_o}), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      mem_rvalid_i = 1'b1;
      mem_rdata_i = 32'hCAFEF00D;
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      check("late_rvalid", 64'({busy_o, load_valid_o, load_data_o}), 64'd0);

      // Final report
      repeat (3) @(negedge clk_i);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
